// File: rtl/regfile_sb.sv
// Register file with scoreboard: two combinational read ports, one write port,
// per-register pending bits with a registered pending count and a stall (Hazard) flag.
// Optional write-to-read bypass is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] AReg,
    input  logic [ADDR_W-1:0] BReg,
    output logic [DATA_W-1:0] Aout,
    output logic [DATA_W-1:0] Bout,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              IssueV,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic              Hazard,
    output logic [ADDR_W:0]   PendCnt,
    input  logic [ADDR_W-1:0] DbgSel,
    output logic [DATA_W-1:0] DbgOut
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic [CNT_W-1:0]  pend_cnt_nxt;
    logic              we_eff;
    logic              issue_eff;
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;
    logic [DATA_W-1:0] stored_dbg;

    // Index 0 is architecturally zero only when ZERO_REG is set.
    function automatic logic is_zero_idx(input logic [ADDR_W-1:0] idx);
        return ZERO_REG && (idx == '0);
    endfunction

    assign we_eff    = WE && !is_zero_idx(WriteReg);
    assign issue_eff = IssueV && !is_zero_idx(IssueReg);

    // Writeback clears first so a same-cycle issue to the same index wins.
    always_comb begin
        pending_nxt = pending;
        if (we_eff) begin
            pending_nxt[WriteReg] = 1'b0;
        end
        if (issue_eff) begin
            pending_nxt[IssueReg] = 1'b1;
        end
    end

    assign pend_cnt_nxt = CNT_W'($countones(pending_nxt));

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            PendCnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else begin
            pending <= pending_nxt;
            PendCnt <= pend_cnt_nxt;
            if (we_eff) begin
                mem[WriteReg] <= WriteData;
            end
        end
    end

    assign stored_a   = is_zero_idx(AReg)   ? '0 : mem[AReg];
    assign stored_b   = is_zero_idx(BReg)   ? '0 : mem[BReg];
    assign stored_dbg = is_zero_idx(DbgSel) ? '0 : mem[DbgSel];

`ifdef REGFILE_BYPASS_EN
    assign hit_a = we_eff && (WriteReg == AReg);
    assign hit_b = we_eff && (WriteReg == BReg);
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    assign Aout   = hit_a ? WriteData : stored_a;
    assign Bout   = hit_b ? WriteData : stored_b;
    assign DbgOut = stored_dbg;

    // A bypassed operand is satisfied this cycle even though its pending bit is still set.
    assign Hazard = (pending[AReg] && !hit_a) || (pending[BReg] && !hit_b);

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one instance with ZERO_REG=0 and one with ZERO_REG=1
// share the same stimulus; expectations are queued by the driver and checked by a monitor.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int S_A   = 0;
    localparam int S_B   = 1;
    localparam int S_HZ  = 2;
    localparam int S_PC  = 3;
    localparam int S_DBG = 4;
    localparam int S_ZA  = 5;
    localparam int S_ZHZ = 6;
    localparam int S_ZPC = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  areg, breg, wreg, ireg, dsel;
    logic        we, issuev;
    logic [15:0] wdata;
    logic [15:0] aout, bout, dbgout, zaout, zbout, zdbgout;
    logic        hazard, zhazard;
    logic [4:0]  pendcnt, zpendcnt;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0)) dut (
        .clk(clk), .rst(rst), .AReg(areg), .BReg(breg), .Aout(aout), .Bout(bout),
        .WE(we), .WriteReg(wreg), .WriteData(wdata), .IssueV(issuev), .IssueReg(ireg),
        .Hazard(hazard), .PendCnt(pendcnt), .DbgSel(dsel), .DbgOut(dbgout)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst(rst), .AReg(areg), .BReg(breg), .Aout(zaout), .Bout(zbout),
        .WE(we), .WriteReg(wreg), .WriteData(wdata), .IssueV(issuev), .IssueReg(ireg),
        .Hazard(zhazard), .PendCnt(zpendcnt), .DbgSel(dsel), .DbgOut(zdbgout)
    );

    typedef struct {
        string       name;
        int          sig;
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic sample_v = 1'b0;

    function automatic logic [15:0] actual(input int s);
        case (s)
            S_A:     return aout;
            S_B:     return bout;
            S_HZ:    return 16'(hazard);
            S_PC:    return 16'(pendcnt);
            S_DBG:   return dbgout;
            S_ZA:    return zaout;
            S_ZHZ:   return 16'(zhazard);
            S_ZPC:   return 16'(zpendcnt);
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_v(input string n, input int s, input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.val  = v;
        q.push_back(e);
    endtask

    // Monitor: pops every expectation queued for the current sampled cycle.
    always @(negedge clk) begin
        if (sample_v) begin
            while (q.size() > 0) begin
                exp_t e;
                logic [15:0] act;
                e   = q.pop_front();
                act = actual(e.sig);
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.val, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we = 1'b0; issuev = 1'b0;
        wreg = '0; wdata = '0; ireg = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        areg = '0; breg = '0; dsel = '0;
        // Reset overrides a same-cycle write and issue.
        rst = 1'b1; we = 1'b1; wreg = 4'd5; wdata = 16'hAAAA; issuev = 1'b1; ireg = 4'd2;
        tick();

        idle();
        for (int i = 0; i < 16; i++) begin
            areg = 4'(i); breg = 4'(15 - i); dsel = 4'(i);
            expect_v("rst_aout", S_A, 16'h0);
            expect_v("rst_bout", S_B, 16'h0);
            expect_v("rst_dbg", S_DBG, 16'h0);
            expect_v("rst_hazard", S_HZ, 16'h0);
            expect_v("rst_pendcnt", S_PC, 16'h0);
            expect_v("rst_zaout", S_ZA, 16'h0);
            sample_v = 1'b1;
            tick();
        end

        // Index 0: real register in dut, hardwired zero in dut_z.
        we = 1'b1; wreg = 4'd0; wdata = 16'hFFFF; issuev = 1'b1; ireg = 4'd0;
        areg = 4'd0; breg = 4'd1; dsel = 4'd0;
        expect_v("r0_wr_aout", S_A, BYP ? 16'hFFFF : 16'h0);
        expect_v("r0_wr_zaout", S_ZA, 16'h0);
        expect_v("r0_wr_hazard", S_HZ, 16'h0);
        expect_v("r0_wr_zhazard", S_ZHZ, 16'h0);
        tick();
        idle();
        expect_v("r0_aout", S_A, 16'hFFFF);
        expect_v("r0_dbg", S_DBG, 16'hFFFF);
        expect_v("r0_hazard", S_HZ, 16'h1);
        expect_v("r0_pendcnt", S_PC, 16'd1);
        expect_v("z0_aout", S_ZA, 16'h0);
        expect_v("z0_hazard", S_ZHZ, 16'h0);
        expect_v("z0_pendcnt", S_ZPC, 16'd0);
        tick();
        we = 1'b1; wreg = 4'd0; wdata = 16'h0000;
        expect_v("r0_clr_hazard", S_HZ, BYP ? 16'h0 : 16'h1);
        expect_v("r0_clr_zhazard", S_ZHZ, 16'h0);
        tick();
        idle();
        expect_v("r0_clr_pendcnt", S_PC, 16'd0);
        expect_v("r0_clr_aout", S_A, 16'h0);
        tick();

        // Write then read back, with and without bypass.
        we = 1'b1; wreg = 4'd5; wdata = 16'h1234; areg = 4'd5; breg = 4'd0; dsel = 4'd5;
        expect_v("w5_same_aout", S_A, BYP ? 16'h1234 : 16'h0);
        expect_v("w5_same_dbg", S_DBG, 16'h0);
        tick();
        idle();
        expect_v("w5_aout", S_A, 16'h1234);
        expect_v("w5_zaout", S_ZA, 16'h1234);
        expect_v("w5_dbg", S_DBG, 16'h1234);
        expect_v("w5_bout", S_B, 16'h0);
        tick();

        // Issue 3, observe hazard, then write back.
        issuev = 1'b1; ireg = 4'd3; areg = 4'd3; breg = 4'd5;
        expect_v("i3_same_hazard", S_HZ, 16'h0);
        expect_v("i3_same_pendcnt", S_PC, 16'd0);
        tick();
        idle();
        expect_v("i3_hazard", S_HZ, 16'h1);
        expect_v("i3_pendcnt", S_PC, 16'd1);
        expect_v("i3_zhazard", S_ZHZ, 16'h1);
        expect_v("i3_zpendcnt", S_ZPC, 16'd1);
        tick();
        we = 1'b1; wreg = 4'd3; wdata = 16'h00AA;
        expect_v("wb3_hazard", S_HZ, BYP ? 16'h0 : 16'h1);
        expect_v("wb3_aout", S_A, BYP ? 16'h00AA : 16'h0);
        expect_v("wb3_pendcnt", S_PC, 16'd1);
        tick();
        idle();
        expect_v("wb3_next_hazard", S_HZ, 16'h0);
        expect_v("wb3_next_aout", S_A, 16'h00AA);
        expect_v("wb3_next_pendcnt", S_PC, 16'd0);
        tick();

        // B-port hazard and re-issue of an already pending index.
        issuev = 1'b1; ireg = 4'd4;
        tick();
        areg = 4'd5; breg = 4'd4;
        expect_v("i4_hazard_b", S_HZ, 16'h1);
        expect_v("i4_pendcnt", S_PC, 16'd1);
        tick();
        idle();
        expect_v("i4_reissue_pendcnt", S_PC, 16'd1);
        expect_v("i4_reissue_hazard", S_HZ, 16'h1);
        tick();

        // Same-cycle issue and writeback to 7: issue wins, data still written.
        issuev = 1'b1; ireg = 4'd7; we = 1'b1; wreg = 4'd7; wdata = 16'hBEEF;
        areg = 4'd7; breg = 4'd5; dsel = 4'd7;
        expect_v("iw7_same_hazard", S_HZ, 16'h0);
        expect_v("iw7_same_aout", S_A, BYP ? 16'hBEEF : 16'h0);
        tick();
        idle();
        breg = 4'd4;
        expect_v("iw7_pendcnt", S_PC, 16'd2);
        expect_v("iw7_hazard", S_HZ, 16'h1);
        expect_v("iw7_dbg", S_DBG, 16'hBEEF);
        expect_v("iw7_aout", S_A, 16'hBEEF);
        tick();

        // Write to a non-pending index leaves pending untouched.
        we = 1'b1; wreg = 4'd9; wdata = 16'h0909; areg = 4'd9; breg = 4'd5;
        expect_v("w9_hazard", S_HZ, 16'h0);
        tick();
        idle();
        expect_v("w9_aout", S_A, 16'h0909);
        expect_v("w9_pendcnt", S_PC, 16'd2);
        tick();

        we = 1'b1; wreg = 4'd4; wdata = 16'h4444; areg = 4'd9; breg = 4'd4;
        expect_v("wb4_hazard", S_HZ, BYP ? 16'h0 : 16'h1);
        expect_v("wb4_bout", S_B, BYP ? 16'h4444 : 16'h0);
        tick();
        we = 1'b1; wreg = 4'd7; wdata = 16'h7777; areg = 4'd7; breg = 4'd4;
        expect_v("wb7_pendcnt", S_PC, 16'd1);
        expect_v("wb7_hazard", S_HZ, BYP ? 16'h0 : 16'h1);
        expect_v("wb7_bout", S_B, 16'h4444);
        tick();
        idle();
        expect_v("wb7_next_pendcnt", S_PC, 16'd0);
        expect_v("wb7_next_hazard", S_HZ, 16'h0);
        expect_v("wb7_next_aout", S_A, 16'h7777);
        tick();

        // Fill every pending bit: count reaches 16 (15 with index 0 hardwired).
        for (int i = 0; i < 16; i++) begin
            issuev = 1'b1; ireg = 4'(i);
            expect_v("fill_pendcnt", S_PC, 16'(i));
            expect_v("fill_zpendcnt", S_ZPC, (i == 0) ? 16'd0 : 16'(i - 1));
            tick();
        end
        issuev = 1'b1; ireg = 4'd5; areg = 4'd0; breg = 4'd0;
        expect_v("full_pendcnt", S_PC, 16'd16);
        expect_v("full_zpendcnt", S_ZPC, 16'd15);
        tick();
        idle();
        expect_v("full_reissue_pendcnt", S_PC, 16'd16);
        expect_v("full_hazard", S_HZ, 16'h1);
        expect_v("full_zhazard", S_ZHZ, 16'h0);
        tick();

        // Mid-sequence reset with write and issue active.
        rst = 1'b1; we = 1'b1; wreg = 4'd9; wdata = 16'h9999; issuev = 1'b1; ireg = 4'd2;
        tick();
        idle();
        areg = 4'd9; breg = 4'd2; dsel = 4'd9;
        expect_v("rst2_pendcnt", S_PC, 16'd0);
        expect_v("rst2_zpendcnt", S_ZPC, 16'd0);
        expect_v("rst2_hazard", S_HZ, 16'h0);
        expect_v("rst2_zhazard", S_ZHZ, 16'h0);
        expect_v("rst2_aout", S_A, 16'h0);
        expect_v("rst2_dbg", S_DBG, 16'h0);
        expect_v("rst2_bout", S_B, 16'h0);
        tick();
        areg = 4'd7; dsel = 4'd3;
        expect_v("rst2_aout7", S_A, 16'h0);
        expect_v("rst2_dbg3", S_DBG, 16'h0);
        tick();
        sample_v = 1'b0;

        repeat (4) tick();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register index width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero.
REQ-004 SHALL have ports, clock and reset first:
  clk  in  1  sole clock, all state updates on rising edge
  rst  in  1  synchronous, active-high reset
  AReg  in  ADDR_W  read port A index
  BReg  in  ADDR_W  read port B index
  Aout  out  DATA_W  read port A data, combinational
  Bout  out  DATA_W  read port B data, combinational
  WE  in  1  write/writeback enable
  WriteReg  in  ADDR_W  write index
  WriteData  in  DATA_W  write data
  IssueV  in  1  instruction issued; destination becomes pending
  IssueReg  in  ADDR_W  issued destination index
  Hazard  out  1  a read operand is pending, pipeline must stall
  PendCnt  out  ADDR_W+1  count of pending registers
  DbgSel  in  ADDR_W  debug read index
  DbgOut  out  DATA_W  debug read data, combinational, never bypassed

Function
REQ-005 Storage SHALL be 2^ADDR_W x DATA_W; WE=1 writes WriteData to WriteReg at the clock edge.
REQ-006 Aout/Bout/DbgOut SHALL show stored contents with zero cycles of latency from an index change.
REQ-007 With ZERO_REG=1: writes to index 0 SHALL be dropped, reads of index 0 SHALL return 0, issues to index 0 SHALL not set pending.
REQ-008 SHALL keep a 2^ADDR_W-bit pending vector: IssueV sets pending[IssueReg]; WE clears pending[WriteReg].
REQ-009 Same-cycle IssueV and WE on the same index: pending SHALL end set (issue wins); data SHALL still be written.
REQ-010 WE to an index that is not pending SHALL write data and leave pending unchanged.
REQ-011 IssueV to an already pending index SHALL keep it set; PendCnt unchanged.
REQ-012 PendCnt SHALL be a register equal to popcount(pending) after every edge; range 0..2^ADDR_W, no wrap.
REQ-013 Hazard SHALL be combinational: (pending[AReg] and not bypass-hit A) or (pending[BReg] and not bypass-hit B); ZERO_REG index 0 never hazards.
REQ-014 Bypass-hit X SHALL be defined as REGFILE_BYPASS_EN compiled in, WE=1, and WriteReg==XReg (excluding index 0 with ZERO_REG=1).

Reset
REQ-015 rst=1 at an edge SHALL clear every register to 0, clear all pending bits, set PendCnt=0.
REQ-016 rst SHALL override same-cycle WE and IssueV; after reset Aout=Bout=DbgOut=0, Hazard=0.
REQ-017 rst asserted mid-sequence SHALL discard all outstanding pending state; no write from that cycle survives.

Configuration
REQ-018 Macro REGFILE_BYPASS_EN defined: on a bypass hit, Aout/Bout SHALL return WriteData in the same cycle and Hazard SHALL ignore that operand's pending bit.
REQ-019 Macro REGFILE_BYPASS_EN undefined: reads SHALL return only stored data; new data visible the cycle after the write; Hazard held until the edge that clears pending.

Verification
REQ-020 rst 1 cycle, then read all indices -> every Aout/Bout = 0, PendCnt=0, Hazard=0.
REQ-021 WE=1, WriteReg=5, WriteData=0x1234; next cycle AReg=5 -> Aout=0x1234; with bypass, Aout=0x1234 in the write cycle itself.
REQ-022 IssueV, IssueReg=3; next cycle AReg=3 -> Hazard=1, PendCnt=1; WE to 3 with 0x00AA -> bypass: Hazard=0 same cycle; no bypass: Hazard=0 next cycle, Aout=0x00AA.
REQ-023 Same cycle IssueV=1/IssueReg=7 and WE=1/WriteReg=7/0xBEEF -> pending[7] set, PendCnt=1, stored value 0xBEEF.
REQ-024 ZERO_REG=1: WE to 0 with 0xFFFF, IssueV to 0 -> Aout(0)=0, Hazard=0, PendCnt=0.
REQ-025 Issue 3 distinct indices, assert rst with WE active -> PendCnt=0, Hazard=0, written index reads 0.
